// File: rtl/dual_port_mem_hs.sv
// Purpose: dual-port word memory with valid/ready write and read-request channels and a registered read-response queue.
// Latency: a read accepted at edge N is visible on rs_* in the cycle after N; writes land at the accepting edge.
// Backpressure: rq_ready drops when the response queue is full, unless a pop happens in the same cycle; w_ready depends on mode only.
module dual_port_mem_hs #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 1024,
    parameter int RESP_DEPTH = 2,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic              rq_valid,
    output logic              rq_ready,
    input  logic [ADDR_W-1:0] rq_addr,
    output logic              rs_valid,
    input  logic              rs_ready,
    output logic [WIDTH-1:0]  rs_data,
    output logic              rs_err
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    localparam logic [ADDR_W:0]    DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   FULL_C   = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(RESP_DEPTH - 1);

    // Storage: data array is never reset; the written flags are what make unwritten reads detectable.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;

    // Response queue.
    logic [WIDTH-1:0] q_data [RESP_DEPTH];
    logic             q_err  [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             w_in_range;
    logic             rq_in_range;
    logic             w_acc;
    logic             rq_acc;
    logic             pop;
    logic             fwd;
    logic [WIDTH-1:0] push_data;
    logic             push_err;

    assign w_in_range  = {1'b0, w_addr}  < DEPTH_C;
    assign rq_in_range = {1'b0, rq_addr} < DEPTH_C;

    // Readies never look at the matching valid; a same-cycle pop frees a slot.
    assign w_ready  = mode[0] && !reset;
    assign rq_ready = mode[1] && !reset && ((count < FULL_C) || (rs_valid && rs_ready));

    assign w_acc  = w_valid && w_ready;
    assign rq_acc = rq_valid && rq_ready;
    assign pop    = rs_valid && rs_ready;

    // Both accepts at once is only possible in mode 3; same in-range address forwards the new data.
    assign fwd = w_acc && rq_acc && w_in_range && (w_addr == rq_addr);

    assign rs_valid = (count != '0);
    assign rs_data  = rs_valid ? q_data[rd_ptr] : '0;
    assign rs_err   = rs_valid ? q_err[rd_ptr]  : 1'b0;

    // Build the response entry: forwarded write, pre-edge array contents, or an out-of-range error.
    always_comb begin
        push_data = '0;
        push_err  = 1'b1;
        if (rq_in_range) begin
            if (fwd) begin
                push_data = w_data;
                push_err  = 1'b0;
            end else begin
                push_data = mem[rq_addr];
                push_err  = !written[rq_addr];
            end
        end
    end

    // Array write; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (w_acc && w_in_range) begin
            mem[w_addr] <= w_data;
        end
    end

    // Track which in-range words have been written since reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written <= '0;
        end else if (w_acc && w_in_range) begin
            written[w_addr] <= 1'b1;
        end
    end

    // Queue entry storage; occupancy is governed by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (rq_acc) begin
            q_data[wr_ptr] <= push_data;
            q_err[wr_ptr]  <= push_err;
        end
    end

    // Queue pointers and occupancy; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (rq_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({rq_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_mem_hs.sv
// Purpose: directed, table-driven check of dual_port_mem_hs plus hand-written corner sequences.
// Latency: responses expected one cycle after read accept.
// Backpressure: exercises full queue, pop-frees-slot, mode-0 drain and async reset flush.
module tb_dual_port_mem_hs;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       w_valid;
    logic [9:0] w_addr;
    logic [7:0] w_data;
    logic       rq_valid;
    logic [9:0] rq_addr;
    logic       rs_ready;

    logic       a_w_ready, a_rq_ready, a_rs_valid, a_rs_err;
    logic [7:0] a_rs_data;
    logic       b_w_ready, b_rq_ready, b_rs_valid, b_rs_err;
    logic [7:0] b_rs_data;

    int n_chk  = 0;
    int n_pass = 0;

    dual_port_mem_hs #(.WIDTH(8), .DEPTH(1024), .RESP_DEPTH(2)) dut_a (
        .clk(clk), .reset(rst), .mode(mode),
        .w_valid(w_valid), .w_ready(a_w_ready), .w_addr(w_addr), .w_data(w_data),
        .rq_valid(rq_valid), .rq_ready(a_rq_ready), .rq_addr(rq_addr),
        .rs_valid(a_rs_valid), .rs_ready(rs_ready), .rs_data(a_rs_data), .rs_err(a_rs_err)
    );

    // Non-power-of-two build so that addresses >= DEPTH are representable.
    dual_port_mem_hs #(.WIDTH(8), .DEPTH(1000), .RESP_DEPTH(2)) dut_b (
        .clk(clk), .reset(rst), .mode(mode),
        .w_valid(w_valid), .w_ready(b_w_ready), .w_addr(w_addr), .w_data(w_data),
        .rq_valid(rq_valid), .rq_ready(b_rq_ready), .rq_addr(rq_addr),
        .rs_valid(b_rs_valid), .rs_ready(rs_ready), .rs_data(b_rs_data), .rs_err(b_rs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m;
        logic       wv;
        logic [9:0] wa;
        logic [7:0] wd;
        logic       rv;
        logic [9:0] ra;
        logic       rsr;
        logic       ew;
        logic       er;
        logic       ev;
        logic [7:0] ed;
        logic       ee;
        logic       cd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [1:0] m, logic wv, logic [9:0] wa, logic [7:0] wd,
                                logic rv, logic [9:0] ra, logic rsr,
                                logic ew, logic er, logic ev, logic [7:0] ed, logic ee, logic cd);
        vec_t v;
        v.m = m; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rsr = rsr;
        v.ew = ew; v.er = er; v.ev = ev; v.ed = ed; v.ee = ee; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic wv, input logic [9:0] wa, input logic [7:0] wd,
                         input logic rv, input logic [9:0] ra, input logic rsr);
        mode = m; w_valid = wv; w_addr = wa; w_data = wd;
        rq_valid = rv; rq_addr = ra; rs_ready = rsr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Write A5@3 / 5A@1023, then read back.
        vt.push_back(mk(2'd1, 1'b1, 10'd3,    8'hA5, 1'b0, 10'd0,    1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));
        vt.push_back(mk(2'd1, 1'b1, 10'd1023, 8'h5A, 1'b1, 10'd3,    1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b1, 10'd5,    8'hFF, 1'b1, 10'd3,    1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd1023, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1));
        // Preload 11@7, 44@9; then forwarding and different-address concurrent access.
        vt.push_back(mk(2'd1, 1'b1, 10'd7,    8'h11, 1'b0, 10'd0,    1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));
        vt.push_back(mk(2'd1, 1'b1, 10'd9,    8'h44, 1'b0, 10'd0,    1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));
        vt.push_back(mk(2'd3, 1'b1, 10'd7,    8'h3C, 1'b1, 10'd7,    1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1));
        vt.push_back(mk(2'd3, 1'b1, 10'd8,    8'h77, 1'b1, 10'd9,    1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd8,    1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd7,    1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1));
        // Stalled write to 5 never landed; 42 never written.
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd5,    1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd42,   1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1));
        // Backpressure: fill, stall third read, pop frees a slot in the same cycle.
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd1023, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd7,    1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd7,    1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1));
        // Two queued, then mode 0 drains them while both channels stall.
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd8,    1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd0, 1'b1, 10'd2,    8'h12, 1'b1, 10'd9,    1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd0, 1'b1, 10'd2,    8'h12, 1'b1, 10'd9,    1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1));
        vt.push_back(mk(2'd0, 1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));
        // Streaming with push+pop at count 1: no bubble; mode 3 write+read every cycle.
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd1023, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1));
        vt.push_back(mk(2'd2, 1'b0, 10'd0,    8'h00, 1'b1, 10'd7,    1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1));
        vt.push_back(mk(2'd3, 1'b1, 10'd3,    8'h99, 1'b1, 10'd1023, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1));
        vt.push_back(mk(2'd3, 1'b1, 10'd1023, 8'hAA, 1'b1, 10'd3,    1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1));
        vt.push_back(mk(2'd3, 1'b1, 10'd4,    8'hBB, 1'b1, 10'd1023, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1));
        vt.push_back(mk(2'd0, 1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));

        // Reset state, with mode 3 driven so the readies must be forced low by reset.
        rst = 1'b1;
        drive(2'd3, 1'b1, 10'd0, 8'h00, 1'b1, 10'd0, 1'b1);
        #12;
        chk("reset.w_ready",  {31'd0, a_w_ready},  32'd0);
        chk("reset.rq_ready", {31'd0, a_rq_ready}, 32'd0);
        chk("reset.rs_valid", {31'd0, a_rs_valid}, 32'd0);
        chk("reset.rs_data",  {24'd0, a_rs_data},  32'd0);
        chk("reset.rs_err",   {31'd0, a_rs_err},   32'd0);
        drive(2'd0, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 1'b1);
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            drive(vt[i].m, vt[i].wv, vt[i].wa, vt[i].wd, vt[i].rv, vt[i].ra, vt[i].rsr);
            #1;
            chk($sformatf("v%0d.w_ready", i),  {31'd0, a_w_ready},  {31'd0, vt[i].ew});
            chk($sformatf("v%0d.rq_ready", i), {31'd0, a_rq_ready}, {31'd0, vt[i].er});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.rs_valid", i), {31'd0, a_rs_valid}, {31'd0, vt[i].ev});
            chk($sformatf("v%0d.rs_err", i),   {31'd0, a_rs_err},   {31'd0, vt[i].ee});
            if (vt[i].cd) begin
                chk($sformatf("v%0d.rs_data", i), {24'd0, a_rs_data}, {24'd0, vt[i].ed});
            end
        end

        // Out-of-range on the DEPTH=1000 build; same stimulus is in range for DEPTH=1024.
        drive(2'd3, 1'b1, 10'd1000, 8'hCD, 1'b1, 10'd1000, 1'b1);
        tick();
        chk("oor.a_fwd_data",  {24'd0, a_rs_data},  32'hCD);
        chk("oor.a_fwd_err",   {31'd0, a_rs_err},   32'd0);
        chk("oor.b_valid",     {31'd0, b_rs_valid}, 32'd1);
        chk("oor.b_data",      {24'd0, b_rs_data},  32'd0);
        chk("oor.b_err",       {31'd0, b_rs_err},   32'd1);
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b1, 10'd1023, 1'b1);
        tick();
        chk("oor.a_1023_data", {24'd0, a_rs_data},  32'hAA);
        chk("oor.b_1023_data", {24'd0, b_rs_data},  32'd0);
        chk("oor.b_1023_err",  {31'd0, b_rs_err},   32'd1);
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b1, 10'd1000, 1'b1);
        tick();
        chk("oor.a_1000_data", {24'd0, a_rs_data},  32'hCD);
        chk("oor.a_1000_err",  {31'd0, a_rs_err},   32'd0);
        chk("oor.b_1000_err",  {31'd0, b_rs_err},   32'd1);
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 1'b1);
        tick();
        chk("oor.b_empty",     {31'd0, b_rs_valid}, 32'd0);

        // Async reset mid-cycle with two responses queued.
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b1, 10'd3, 1'b0);
        tick();
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b1, 10'd7, 1'b0);
        tick();
        drive(2'd3, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 1'b0);
        #1;
        chk("prerst.rs_valid", {31'd0, a_rs_valid}, 32'd1);
        chk("prerst.rs_data",  {24'd0, a_rs_data},  32'h99);
        chk("prerst.rq_full",  {31'd0, a_rq_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.rs_valid",   {31'd0, a_rs_valid}, 32'd0);
        chk("arst.rs_data",    {24'd0, a_rs_data},  32'd0);
        chk("arst.w_ready",    {31'd0, a_w_ready},  32'd0);
        tick();
        rst = 1'b0;
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 1'b1);
        tick();
        chk("postrst.rs_valid", {31'd0, a_rs_valid}, 32'd0);
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b1, 10'd3, 1'b1);
        tick();
        chk("postrst.valid3",  {31'd0, a_rs_valid}, 32'd1);
        chk("postrst.err3",    {31'd0, a_rs_err},   32'd1);
        drive(2'd2, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 1'b1);
        tick();
        chk("postrst.empty",   {31'd0, a_rs_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
